vma_addr_unit: RTL
==================

// Module: vma_addr_unit
// PURPOSE
//  Parametrised virtual-memory-address unit for the EBOX: holds VMA, PC and VMA HELD,
//  selects/increments the next VMA, flags AC references and section 0, compares VMA
//  against an address-break register, and returns diagnostic words on the EBUS.
//  Generalises the fixed 13..35 VMA board to any width and adds an optional VMA history ring.
// PARAMETERS
//  ADDR_W      23  VMA width (bits 13..35 of a KL word); MSB = PDP-10 bit 13
//  OFS_W       18  in-section offset width; SECT_W = ADDR_W-OFS_W (derived localparam)
//  AC_W         4  AC address width; AC ref when offset[OFS_W-1:AC_W]==0
//  HIST_DEPTH   8  history ring entries, power of 2, >=2
//  EBUS_W      36  diagnostic EBUS data width
// PORTS
//  clk          in   1        EBOX clock, all state on rising edge
//  reset        in   1        synchronous, active-high
//  ad           in   ADDR_W   adder output (AD 13..35)
//  vma_load     in   1        load VMA from source chosen by vma_sel
//  vma_sel      in   2        0=AD 1=PC 2=HELD 3=PREV (prev_sect ++ ad offset)
//  vma_inc      in   1        add 1 to offset of next VMA (alone: VMA<=VMA+1)
//  vma_ext      in   1        1: section bits taken from source; 0: current section kept
//  prev_sect    in   SECT_W   previous-context section
//  load_pc      in   1        PC <= VMA (current register value)
//  load_held    in   1        VMA HELD <= VMA
//  local_ac     in   1        global-AC context suppresses AC ref outside section 0 when 0
//  brk_addr     in   ADDR_W   address-break compare value
//  brk_en       in   1        enable match
//  hist_clear   in   1        clear history ring and freeze
//  diag_read    in   1        EBUS diagnostic read strobe
//  diag_sel     in   3        0=VMA 1=PC 2=HELD 3=BRK 4=HIST status 5=HIST entry
//  diag_idx     in   $clog2(HIST_DEPTH)  history index, 0 = newest
//  vma          out  ADDR_W   VMA register
//  pc           out  ADDR_W   PC register
//  vma_held     out  ADDR_W   VMA HELD register
//  ac_ref       out  1        VMA addresses an AC
//  vma_sect0    out  1        VMA section field == 0
//  pc_sect0     out  1        PC section field == 0
//  match        out  1        registered address-break match
//  ebus_d       out  EBUS_W   diag data, zero unless diag_read was high last cycle
// BEHAVIOUR
//  - Reset: vma, pc, vma_held, match, ebus_d, history state = 0; hence vma_sect0=pc_sect0=1, ac_ref=1.
//  - Next VMA: src per vma_sel if vma_load else vma; section = vma_ext ? src.sect : vma.sect;
//    offset = src.ofs + vma_inc, wraps mod 2^OFS_W, never carries into section.
//  - load_pc/load_held capture the pre-edge VMA; simultaneous with vma_load they get old value.
//  - ac_ref, vma_sect0, pc_sect0 combinational from registers (1-cycle latency from load).
//    ac_ref = ofs[OFS_W-1:AC_W]==0 && (vma_sect0 || local_ac).
//  - match <= brk_en && (next VMA == brk_addr) when vma_load|vma_inc; else holds; cleared by !brk_en.
//  - ebus_d registered: 1 cycle after diag_read, zero-extended selected word; unused codes read 0.
//  - Reset wins over every other input; a load in the reset cycle is discarded.
// CONFIGURATION
//  VMA_HISTORY_EN defined: each cycle with vma_load|vma_inc pushes the new VMA into ring;
//   write ptr wraps at HIST_DEPTH, count saturates at HIST_DEPTH, oldest overwritten.
//   Rising match freezes ring (pushes ignored) until hist_clear; hist_clear and push same
//   cycle: clear wins. diag_sel 4 = {frozen, count}; 5 = entry diag_idx (idx>=count reads 0).
//  Not defined: no ring storage; diag_sel 4 and 5 read 0; all other behaviour identical.
// STRUCTURE
//  Package vma_pkg: vma_sel_e (VSEL_AD/PC/HELD/PREV), diag_sel_e codes, section/offset split
//   helper functions. Sub-module vma_hist_ring (ring buffer + count + freeze), instanced only
//   under VMA_HISTORY_EN.
// TESTING
//  1 reset then read diag 0..3 -> all 0; vma_sect0=1, ac_ref=1.
//  2 ad=0o0_777777, sel=AD, load+inc, vma_ext=0 -> vma=0o0_000000 (offset wraps, section kept).
//  3 vma=0o5_000010, local_ac=0 -> ac_ref=0; local_ac=1 -> ac_ref=1; vma=0o0_000020 -> ac_ref=0.
//  4 brk_addr=0o3_001000, brk_en=1, load AD=same -> match=1 next cycle; load other -> match=0.
//  5 (HISTORY_EN, DEPTH=8) 10 loads of 1..10 -> status count=8, idx0=10, idx7=3; match freezes ring.
//  6 load and load_pc same edge -> pc = prior VMA, vma = new value.

Source files
------------

// File: rtl/vma_pkg.sv
// Shared types and section/offset helpers for the VMA address unit.
// Helpers work on a wide container word so that any ADDR_W/OFS_W split can use them.
package vma_pkg;

  typedef enum logic [1:0] {
    VSEL_AD   = 2'd0,
    VSEL_PC   = 2'd1,
    VSEL_HELD = 2'd2,
    VSEL_PREV = 2'd3
  } vma_sel_e;

  typedef enum logic [2:0] {
    DIAG_VMA    = 3'd0,
    DIAG_PC     = 3'd1,
    DIAG_HELD   = 3'd2,
    DIAG_BRK    = 3'd3,
    DIAG_HSTAT  = 3'd4,
    DIAG_HENTRY = 3'd5
  } diag_sel_e;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] sect_of(input logic [MAX_W-1:0] a, input int ofs_w);
    return a >> ofs_w;
  endfunction

  function automatic logic [MAX_W-1:0] ofs_of(input logic [MAX_W-1:0] a, input int ofs_w);
    return a & ((MAX_W'(1) << ofs_w) - MAX_W'(1));
  endfunction

  function automatic logic [MAX_W-1:0] join_addr(input logic [MAX_W-1:0] sect,
                                                 input logic [MAX_W-1:0] ofs,
                                                 input int ofs_w);
    return (sect << ofs_w) | ofs;
  endfunction

endpackage

// File: rtl/vma_hist_ring.sv
// VMA history ring: newest-first readback, saturating count, freeze until cleared.
// Only instantiated when VMA_HISTORY_EN is defined.
module vma_hist_ring
  import vma_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int HIST_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_data,
  input  logic                          freeze_set,
  input  logic                          clear,
  input  logic [$clog2(HIST_DEPTH)-1:0] rd_idx,
  output logic                          frozen,
  output logic [$clog2(HIST_DEPTH):0]   count,
  output logic [ADDR_W-1:0]             rd_data
);

  localparam int IDX_W = $clog2(HIST_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [ADDR_W-1:0] mem [HIST_DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  rd_ptr;
  logic              do_push;

  assign do_push = push && !frozen;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      count  <= '0;
      frozen <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + IDX_W'(1);
        if (count != CNT_W'(HIST_DEPTH)) count <= count + CNT_W'(1);
      end
      if (freeze_set) frozen <= 1'b1;
    end
  end

  // Storage is not reset: entries at or beyond count are masked on read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign rd_ptr  = wr_ptr - IDX_W'(1) - rd_idx;
  assign rd_data = ({1'b0, rd_idx} < count) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/vma_addr_unit.sv
// EBOX virtual-memory-address unit: VMA/PC/HELD registers, AC/section flags,
// address-break match and EBUS diagnostics. Optional history ring: VMA_HISTORY_EN.
module vma_addr_unit
  import vma_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int OFS_W      = 18,
  parameter int AC_W       = 4,
  parameter int HIST_DEPTH = 8,
  parameter int EBUS_W     = 36
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             ad,
  input  logic                          vma_load,
  input  logic [1:0]                    vma_sel,
  input  logic                          vma_inc,
  input  logic                          vma_ext,
  input  logic [ADDR_W-OFS_W-1:0]       prev_sect,
  input  logic                          load_pc,
  input  logic                          load_held,
  input  logic                          local_ac,
  input  logic [ADDR_W-1:0]             brk_addr,
  input  logic                          brk_en,
  input  logic                          hist_clear,
  input  logic                          diag_read,
  input  logic [2:0]                    diag_sel,
  input  logic [$clog2(HIST_DEPTH)-1:0] diag_idx,
  output logic [ADDR_W-1:0]             vma,
  output logic [ADDR_W-1:0]             pc,
  output logic [ADDR_W-1:0]             vma_held,
  output logic                          ac_ref,
  output logic                          vma_sect0,
  output logic                          pc_sect0,
  output logic                          match,
  output logic [EBUS_W-1:0]             ebus_d
);

  localparam int SECT_W = ADDR_W - OFS_W;
  localparam int HIDX_W = $clog2(HIST_DEPTH);

  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] vma_nxt;
  logic [SECT_W-1:0] vma_sect, pc_sect, nxt_sect;
  logic [OFS_W-1:0]  vma_ofs, nxt_ofs;
  logic              advance;
  logic              match_nxt;
  logic [EBUS_W-1:0] diag_word;
  logic [HIDX_W+1:0] hist_stat;
  logic [ADDR_W-1:0] hist_entry;

  assign vma_sect = SECT_W'(sect_of(MAX_W'(vma), OFS_W));
  assign pc_sect  = SECT_W'(sect_of(MAX_W'(pc), OFS_W));
  assign vma_ofs  = OFS_W'(ofs_of(MAX_W'(vma), OFS_W));

  always_comb begin
    src = vma;
    if (vma_load) begin
      case (vma_sel_e'(vma_sel))
        VSEL_AD:   src = ad;
        VSEL_PC:   src = pc;
        VSEL_HELD: src = vma_held;
        VSEL_PREV: src = ADDR_W'(join_addr(MAX_W'(prev_sect), ofs_of(MAX_W'(ad), OFS_W), OFS_W));
      endcase
    end
  end

  // Offset increment wraps inside the section; the carry is dropped on purpose.
  assign nxt_sect = vma_ext ? SECT_W'(sect_of(MAX_W'(src), OFS_W)) : vma_sect;
  assign nxt_ofs  = OFS_W'(ofs_of(MAX_W'(src), OFS_W)) + OFS_W'(vma_inc);
  assign vma_nxt  = {nxt_sect, nxt_ofs};

  assign advance   = vma_load | vma_inc;
  assign match_nxt = brk_en && (advance ? (vma_nxt == brk_addr) : match);

  assign vma_sect0 = (vma_sect == '0);
  assign pc_sect0  = (pc_sect == '0);
  assign ac_ref    = ((vma_ofs >> AC_W) == '0) && (vma_sect0 || local_ac);

`ifdef VMA_HISTORY_EN
  logic                hist_frozen;
  logic [HIDX_W:0]     hist_count;

  vma_hist_ring #(
    .ADDR_W     (ADDR_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk        (clk),
    .reset      (reset),
    .push       (advance),
    .push_data  (vma_nxt),
    .freeze_set (match_nxt && !match),
    .clear      (hist_clear),
    .rd_idx     (diag_idx),
    .frozen     (hist_frozen),
    .count      (hist_count),
    .rd_data    (hist_entry)
  );

  assign hist_stat = {hist_frozen, hist_count};
`else
  logic unused_hist;

  assign unused_hist = ^{hist_clear, diag_idx};
  assign hist_stat   = '0;
  assign hist_entry  = '0;
`endif

  always_comb begin
    diag_word = '0;
    case (diag_sel_e'(diag_sel))
      DIAG_VMA:    diag_word = EBUS_W'(vma);
      DIAG_PC:     diag_word = EBUS_W'(pc);
      DIAG_HELD:   diag_word = EBUS_W'(vma_held);
      DIAG_BRK:    diag_word = EBUS_W'(brk_addr);
      DIAG_HSTAT:  diag_word = EBUS_W'(hist_stat);
      DIAG_HENTRY: diag_word = EBUS_W'(hist_entry);
      default:     diag_word = '0;
    endcase
  end

  // Register stage: PC/HELD sample the pre-edge VMA, so a same-edge load sees the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      vma      <= '0;
      pc       <= '0;
      vma_held <= '0;
      match    <= 1'b0;
      ebus_d   <= '0;
    end else begin
      vma    <= vma_nxt;
      match  <= match_nxt;
      ebus_d <= diag_read ? diag_word : '0;
      if (load_pc)   pc       <= vma;
      if (load_held) vma_held <= vma;
    end
  end

endmodule
